sorteio_papeis: RTL and testbench

- Game datapath block that the game control unit drives during game setup.
- Captures a seed from a free-running counter when `e_seed_reg` pulses.
- On `iniciar`, builds the fixed role deck and shuffles it with an LFSR-driven Fisher–Yates pass, then raises `pronto`.
- After that it serves per-player role lookups to the night/day phases.

---
 rtl/sorteio_papeis_if.sv | 21 ++
 rtl/sorteio_papeis.sv | 152 +++++++++++++++
 tb/tb_sorteio_papeis.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sorteio_papeis_if.sv
// Setup-phase bus between the game control unit and the role-draw datapath.
interface sorteio_papeis_if;
  logic        zera_CS;
  logic        e_seed_reg;
  logic        iniciar;
  logic [3:0]  endereco_jogador;
  logic [1:0]  papel;
  logic        pronto;
  logic [15:0] db_seed;
  logic [2:0]  db_estado;

  modport master (
    output zera_CS, e_seed_reg, iniciar, endereco_jogador,
    input  papel, pronto, db_seed, db_estado
  );

  modport slave (
    input  zera_CS, e_seed_reg, iniciar, endereco_jogador,
    output papel, pronto, db_seed, db_estado
  );
endinterface

// File: rtl/sorteio_papeis.sv
// Role draw datapath: captures a seed, builds the fixed role deck and shuffles it with an
// LFSR-driven Fisher-Yates pass, then serves per-player role lookups.
module sorteio_papeis #(
  parameter int unsigned N_JOGADORES = 8,
  parameter int unsigned N_LOBOS     = 2
) (
  input logic        clock,
  input logic        reset,
  sorteio_papeis_if.slave bus
);

  localparam logic [15:0] LfsrInit      = 16'hACE1;
  localparam logic [15:0] LfsrTaps      = 16'hB400;
  localparam logic [3:0]  UltimoJogador = 4'(N_JOGADORES - 1);

  // Roles: 0 aldeao, 1 lobo, 2 vidente, 3 medico
  localparam logic [1:0] Aldeao  = 2'd0;
  localparam logic [1:0] Lobo    = 2'd1;
  localparam logic [1:0] Vidente = 2'd2;
  localparam logic [1:0] Medico  = 2'd3;

  typedef enum logic [2:0] {
    StOcioso   = 3'd0,
    StPreenche = 3'd1,
    StSorteia  = 3'd2,
    StTroca    = 3'd3,
    StPronto   = 3'd4
  } estado_e;

  estado_e     estado_q, estado_d;
  logic [15:0] cnt_q, seed_q, lfsr_q, lfsr_next;
  logic [3:0]  k_q, i_q, j_q, j_sorteado;
  // Sized to the full address space so entries beyond N_JOGADORES simply stay 0
  logic [1:0]  papel_q [16];
  logic [1:0]  carta_k;
  logic        aceita_inicio, aceita_j;

  assign lfsr_next     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  assign j_sorteado    = lfsr_q[3:0];
  assign aceita_j      = (j_sorteado <= i_q);
  assign aceita_inicio = bus.iniciar && (estado_q == StOcioso || estado_q == StPronto);
  assign bus.db_seed   = seed_q;

  // Deck card for fill position k: wolves first, then seer, doctor, villagers
  always_comb begin
    carta_k = Aldeao;
    if (32'(k_q) < N_LOBOS) begin
      carta_k = Lobo;
    end else if (32'(k_q) == N_LOBOS) begin
      carta_k = Vidente;
    end else if (32'(k_q) == N_LOBOS + 1) begin
      carta_k = Medico;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StOcioso;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM next state; clear overrides everything
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StOcioso:   if (bus.iniciar) estado_d = StPreenche;
      StPreenche: if (k_q == UltimoJogador) estado_d = StSorteia;
      StSorteia:  if (aceita_j) estado_d = StTroca;
      StTroca:    estado_d = (i_q == 4'd1) ? StPronto : StSorteia;
      StPronto:   if (bus.iniciar) estado_d = StPreenche;
      default:    estado_d = StOcioso;
    endcase
    if (bus.zera_CS) estado_d = StOcioso;
  end

  // FSM outputs and combinational role readout
  always_comb begin
    bus.pronto = (estado_q == StPronto);
    case (estado_q)
      StOcioso, StPreenche, StSorteia, StTroca, StPronto: bus.db_estado = estado_q;
      default:                                            bus.db_estado = 3'b111;
    endcase
    bus.papel = Aldeao;
    if ({1'b0, bus.endereco_jogador} < 5'(N_JOGADORES)) begin
      bus.papel = papel_q[bus.endereco_jogador];
    end
  end

  // Free-running seed counter and seed capture register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      seed_q <= '0;
    end else if (bus.zera_CS) begin
      cnt_q  <= '0;
      seed_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
      if (bus.e_seed_reg) seed_q <= cnt_q;
    end
  end

  // LFSR and shuffle indices
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= LfsrInit;
      k_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (bus.zera_CS) begin
      lfsr_q <= LfsrInit;
      k_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (aceita_inicio) begin
      // A zero seed would lock the LFSR, so it is replaced by the reset pattern
      lfsr_q <= (seed_q == 16'h0000) ? LfsrInit : seed_q;
      k_q    <= '0;
    end else begin
      case (estado_q)
        StPreenche: begin
          if (k_q == UltimoJogador) i_q <= UltimoJogador;
          else                      k_q <= k_q + 4'd1;
        end
        StSorteia: begin
          lfsr_q <= lfsr_next;
          if (aceita_j) j_q <= j_sorteado;
        end
        StTroca: i_q <= i_q - 4'd1;
        default: ;
      endcase
    end
  end

  // Role array: deck fill, then pairwise swaps; frozen otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 16; p++) papel_q[p] <= Aldeao;
    end else if (bus.zera_CS) begin
      for (int p = 0; p < 16; p++) papel_q[p] <= Aldeao;
    end else if (estado_q == StPreenche) begin
      papel_q[k_q] <= carta_k;
    end else if (estado_q == StTroca) begin
      papel_q[i_q] <= papel_q[j_q];
      papel_q[j_q] <= papel_q[i_q];
    end
  end

endmodule

// File: tb/tb_sorteio_papeis.sv
// Self-checking bench for sorteio_papeis: seed capture table, model-checked shuffles,
// and hand-written sequences for clear, ignored start, simultaneous events and reset.
module tb_sorteio_papeis;

  localparam int N  = 8;
  localparam int NL = 2;

  logic clock = 1'b0;
  logic reset;

  sorteio_papeis_if bus ();

  sorteio_papeis #(
    .N_JOGADORES(N),
    .N_LOBOS    (NL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] exp_role [16];
  int         exp_lat;

  typedef struct {
    int          espera;
    logic [15:0] seed_esperada;
  } vet_seed_t;

  vet_seed_t tab [5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_passo(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Fisher-Yates over the fixed deck, drawing j from the low nibble with rejection
  task automatic modelo(input logic [15:0] seed);
    logic [15:0] s;
    logic [1:0]  t;
    int          j;
    for (int p = 0; p < 16; p++) begin
      if (p >= N)           exp_role[p] = 2'd0;
      else if (p < NL)      exp_role[p] = 2'd1;
      else if (p == NL)     exp_role[p] = 2'd2;
      else if (p == NL + 1) exp_role[p] = 2'd3;
      else                  exp_role[p] = 2'd0;
    end
    s       = (seed == 16'h0000) ? 16'hACE1 : seed;
    exp_lat = 1 + N;
    for (int i = N - 1; i >= 1; i--) begin
      do begin
        j = int'(s[3:0]);
        s = lfsr_passo(s);
        exp_lat++;
      end while (j > i);
      t           = exp_role[i];
      exp_role[i] = exp_role[j];
      exp_role[j] = t;
      exp_lat++;
    end
  endtask

  // Clear, wait n cycles, then latch the counter (value n)
  task automatic captura(input int n);
    bus.zera_CS = 1'b1;
    tick();
    bus.zera_CS = 1'b0;
    repeat (n) tick();
    bus.e_seed_reg = 1'b1;
    tick();
    bus.e_seed_reg = 1'b0;
  endtask

  // Pulse iniciar and count cycles until pronto; optional second iniciar at cycle extra_em
  task automatic embaralha(input string nome, input int extra_em, input bit com_seed,
                           output int lat);
    bus.iniciar    = 1'b1;
    bus.e_seed_reg = com_seed;
    tick();
    bus.iniciar    = 1'b0;
    bus.e_seed_reg = 1'b0;
    lat = 1;
    while (!bus.pronto && lat < 3000) begin
      if (lat == extra_em) bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      lat++;
    end
    check({nome, " pronto"}, 32'(bus.pronto), 32'd1);
  endtask

  task automatic confere_papeis(input string nome);
    int cont [4];
    cont = '{0, 0, 0, 0};
    for (int a = 0; a < N; a++) begin
      bus.endereco_jogador = 4'(a);
      tick();
      check($sformatf("%s papel[%0d]", nome, a), 32'(bus.papel), 32'(exp_role[a]));
      cont[bus.papel]++;
    end
    check({nome, " n_lobo"},    32'(cont[1]), 32'(NL));
    check({nome, " n_vidente"}, 32'(cont[2]), 32'd1);
    check({nome, " n_medico"},  32'(cont[3]), 32'd1);
    check({nome, " n_aldeao"},  32'(cont[0]), 32'(N - NL - 2));
    bus.endereco_jogador = 4'd12;
    tick();
    check({nome, " endereco 12"}, 32'(bus.papel), 32'd0);
    check({nome, " estado"}, 32'(bus.db_estado), 32'd4);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int espera;

    tab[0] = '{100, 16'd100};
    tab[1] = '{0, 16'd0};
    tab[2] = '{1, 16'd1};
    tab[3] = '{999, 16'd999};
    tab[4] = '{65536, 16'd0};

    bus.zera_CS          = 1'b0;
    bus.e_seed_reg       = 1'b0;
    bus.iniciar          = 1'b0;
    bus.endereco_jogador = 4'd0;
    reset                = 1'b1;
    #12;
    check("reset pronto",  32'(bus.pronto),    32'd0);
    check("reset estado",  32'(bus.db_estado), 32'd0);
    check("reset db_seed", 32'(bus.db_seed),   32'd0);
    check("reset papel",   32'(bus.papel),     32'd0);
    reset = 1'b0;
    tick();

    // Seed capture table; the wrap case runs last and leaves seed 0 in OCIOSO
    for (int t = 0; t < 5; t++) begin
      captura(tab[t].espera);
      check($sformatf("seed_cap espera=%0d", tab[t].espera), 32'(bus.db_seed),
            32'(tab[t].seed_esperada));
    end

    // Zero seed shuffles as if seeded with ACE1
    check("ocioso antes seed0", 32'(bus.db_estado), 32'd0);
    modelo(16'h0000);
    embaralha("seed0", -1, 1'b0, lat);
    check("seed0 latencia", 32'(lat), 32'(exp_lat));
    confere_papeis("seed0");

    // Randomized seeds against the model
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 400));
      captura(n);
      modelo(16'(n));
      embaralha($sformatf("rand seed=%0d", n), -1, 1'b0, lat);
      check($sformatf("rand seed=%0d latencia", n), 32'(lat), 32'(exp_lat));
      confere_papeis($sformatf("rand seed=%0d", n));
    end

    // Seed 100, then a second iniciar from PRONTO must reproduce it exactly
    captura(100);
    modelo(16'd100);
    embaralha("seed100", -1, 1'b0, lat);
    check("seed100 latencia", 32'(lat), 32'(exp_lat));
    confere_papeis("seed100");
    embaralha("repete", -1, 1'b0, lat);
    check("repete latencia", 32'(lat), 32'(exp_lat));
    confere_papeis("repete");

    // iniciar during PREENCHE must not restart the fill
    embaralha("ignora", 3, 1'b0, lat);
    check("ignora latencia", 32'(lat), 32'(exp_lat));
    confere_papeis("ignora");

    // e_seed_reg with iniciar from OCIOSO: shuffle uses the old seed (50), counter is 51
    captura(50);
    modelo(16'd50);
    embaralha("simultaneo", -1, 1'b1, lat);
    check("simultaneo latencia", 32'(lat), 32'(exp_lat));
    check("simultaneo db_seed", 32'(bus.db_seed), 32'd51);
    confere_papeis("simultaneo");

    // Clear in the middle of SORTEIA
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    espera = 0;
    while (bus.db_estado != 3'd2 && espera < 50) begin
      tick();
      espera++;
    end
    check("espera sorteia", 32'(bus.db_estado), 32'd2);
    bus.zera_CS = 1'b1;
    tick();
    bus.zera_CS = 1'b0;
    check("zera estado",  32'(bus.db_estado), 32'd0);
    check("zera pronto",  32'(bus.pronto),    32'd0);
    check("zera db_seed", 32'(bus.db_seed),   32'd0);
    for (int a = 0; a < N; a++) begin
      bus.endereco_jogador = 4'(a);
      tick();
      check($sformatf("zera papel[%0d]", a), 32'(bus.papel), 32'd0);
    end

    // Asynchronous reset asserted mid-cycle from PRONTO
    captura(7);
    modelo(16'd7);
    embaralha("pre reset", -1, 1'b0, lat);
    check("pre reset latencia", 32'(lat), 32'(exp_lat));
    #2;
    reset = 1'b1;
    #1;
    check("async reset pronto",  32'(bus.pronto),    32'd0);
    check("async reset estado",  32'(bus.db_estado), 32'd0);
    check("async reset db_seed", 32'(bus.db_seed),   32'd0);
    for (int a = 0; a < 16; a++) begin
      bus.endereco_jogador = 4'(a);
      #1;
      check($sformatf("async reset papel[%0d]", a), 32'(bus.papel), 32'd0);
    end
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
